// File: rtl/comb_op_sequencer_if.sv
// comb_op_sequencer_if: command and result handshake bundle of comb_op_sequencer.
// master drives commands and accepts results; slave is the sequencer.
interface comb_op_sequencer_if #(
  parameter int REPEAT_W = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [7:0]          cmd_data;
  logic [1:0]          cmd_const;
  logic [1:0]          cmd_op;
  logic [REPEAT_W-1:0] cmd_repeat;
  logic                res_valid;
  logic                res_ready;
  logic [7:0]          res_data;
  logic                res_zero;
  logic [REPEAT_W:0]   res_iters;

  modport master (
    output cmd_valid, cmd_data, cmd_const, cmd_op, cmd_repeat, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_iters
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_const, cmd_op, cmd_repeat, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_iters
  );
endinterface

// File: rtl/comb_op_sequencer.sv
// comb_op_sequencer: iterates the 8-bit constant ALU, feeding its result back
// as the next operand for cmd_repeat+1 rounds, then offers the final value.
// Optional feature: define SEQ_ZERO_STOP_EN to end a command early on the
// first iteration whose ALU result is zero.
module comb_op_sequencer #(
  parameter int REPEAT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  comb_op_sequencer_if.slave     bus,
  output logic [7:0]             alu_input,
  output logic [1:0]             alu_const_sel,
  output logic [1:0]             alu_op,
  input  logic [7:0]             alu_output,
  input  logic                   alu_status
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [REPEAT_W:0]   ITER_ONE = 1;
  localparam logic [REPEAT_W-1:0] CNT_ONE  = 1;

  state_t              state;
  logic [REPEAT_W-1:0] cnt;
  logic [REPEAT_W:0]   iters;
  logic [REPEAT_W:0]   iters_nxt;
  logic                stop;

  assign iters_nxt = iters + ITER_ONE;

`ifdef SEQ_ZERO_STOP_EN
  // a zero result finishes the command; that iteration still counts
  assign stop = (cnt == '0) || alu_status;
`else
  // fixed iteration count; status is not consulted
  logic unused_alu_status;
  assign unused_alu_status = alu_status;
  assign stop = (cnt == '0);
`endif

  // Command FSM; alu_input doubles as the accumulator while in RUN, and every
  // output is a register so nothing on cmd_*/res_ready reaches an output combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      iters         <= '0;
      alu_input     <= '0;
      alu_const_sel <= '0;
      alu_op        <= '0;
      bus.cmd_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_zero  <= 1'b0;
      bus.res_iters <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state         <= RUN;
            cnt           <= bus.cmd_repeat;
            iters         <= '0;
            alu_input     <= bus.cmd_data;
            alu_const_sel <= bus.cmd_const;
            alu_op        <= bus.cmd_op;
            bus.cmd_ready <= 1'b0;
          end
        end
        RUN: begin
          iters <= iters_nxt;
          if (stop) begin
            state         <= DONE;
            alu_input     <= '0;
            alu_const_sel <= '0;
            alu_op        <= '0;
            bus.res_valid <= 1'b1;
            bus.res_data  <= alu_output;
            bus.res_zero  <= (alu_output == 8'd0);
            bus.res_iters <= iters_nxt;
          end else begin
            cnt       <= cnt - CNT_ONE;
            alu_input <= alu_output;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_zero  <= 1'b0;
            bus.res_iters <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_op_sequencer.sv
// tb_comb_op_sequencer: directed bench with an ALU model and a result scoreboard.
module tb_comb_op_sequencer;

  localparam int REPEAT_W = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       z;
    logic [4:0] it;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] alu_input;
  logic [1:0] alu_const_sel;
  logic [1:0] alu_op;
  logic [7:0] alu_output;
  logic       alu_status;
  logic [7:0] kval;

  int   vectors;
  int   miscompares;
  exp_t sbq[$];

  comb_op_sequencer_if #(.REPEAT_W(REPEAT_W)) bus ();

  comb_op_sequencer #(.REPEAT_W(REPEAT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus.slave),
    .alu_input     (alu_input),
    .alu_const_sel (alu_const_sel),
    .alu_op        (alu_op),
    .alu_output    (alu_output),
    .alu_status    (alu_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural constant ALU: constants 1,3,5,7; add/sub/and/or mod 256
  always_comb begin
    kval = {5'b0, alu_const_sel, 1'b1};
    case (alu_op)
      2'd0:    alu_output = alu_input + kval;
      2'd1:    alu_output = alu_input - kval;
      2'd2:    alu_output = alu_input & kval;
      default: alu_output = alu_input | kval;
    endcase
    alu_status = (alu_output == 8'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_data"},  bus.res_data, 0);
    check({tag, "_res_zero"},  bus.res_zero, 0);
    check({tag, "_res_iters"}, bus.res_iters, 0);
    check({tag, "_alu_input"}, alu_input, 0);
    check({tag, "_alu_sel"},   alu_const_sel, 0);
    check({tag, "_alu_op"},    alu_op, 0);
  endtask

  // issue one command, check latency and result, optionally stall the result
  task automatic run_cmd(input string tag, input logic [7:0] d, input logic [1:0] c,
                         input logic [1:0] o, input logic [3:0] r, input logic [7:0] ed,
                         input logic ez, input logic [4:0] ei, input int stall);
    int   n;
    exp_t e;
    check({tag, "_idle_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_data   = d;
    bus.cmd_const  = c;
    bus.cmd_op     = o;
    bus.cmd_repeat = r;
    tick();
    e.d = ed; e.z = ez; e.it = ei;
    sbq.push_back(e);
    check({tag, "_acc_ready"}, bus.cmd_ready, 0);
    check({tag, "_acc_in"},    alu_input, d);
    check({tag, "_acc_sel"},   alu_const_sel, c);
    check({tag, "_acc_op"},    alu_op, o);
    n = 0;
    while (!bus.res_valid && n < 40) begin
      // junk on cmd_* must not disturb the latched command
      bus.cmd_valid  = 1'b1;
      bus.cmd_data   = 8'($urandom);
      bus.cmd_const  = 2'($urandom);
      bus.cmd_op     = 2'($urandom);
      bus.cmd_repeat = 4'($urandom);
      tick();
      n++;
      if (!bus.res_valid) begin
        check({tag, "_run_sel"},   alu_const_sel, c);
        check({tag, "_run_op"},    alu_op, o);
        check({tag, "_run_ready"}, bus.cmd_ready, 0);
      end
    end
    if (n >= 40) check({tag, "_res_valid_timeout"}, bus.res_valid, 1);
    check({tag, "_latency"}, n, ei);
    e = sbq.pop_front();
    check({tag, "_res_data"},  bus.res_data, e.d);
    check({tag, "_res_zero"},  bus.res_zero, e.z);
    check({tag, "_res_iters"}, bus.res_iters, e.it);
    check({tag, "_done_in"},   alu_input, 0);
    check({tag, "_done_sel"},  alu_const_sel, 0);
    check({tag, "_done_op"},   alu_op, 0);
    check({tag, "_done_ready"}, bus.cmd_ready, 0);
    for (int i = 0; i < stall; i++) begin
      bus.cmd_valid = ~bus.cmd_valid;
      bus.cmd_data  = 8'($urandom);
      bus.cmd_op    = 2'($urandom);
      tick();
      check({tag, "_stall_valid"}, bus.res_valid, 1);
      check({tag, "_stall_data"},  bus.res_data, e.d);
      check({tag, "_stall_zero"},  bus.res_zero, e.z);
      check({tag, "_stall_iters"}, bus.res_iters, e.it);
      check({tag, "_stall_ready"}, bus.cmd_ready, 0);
      check({tag, "_stall_in"},    alu_input, 0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_post_ready"}, bus.cmd_ready, 1);
    check({tag, "_post_valid"}, bus.res_valid, 0);
  endtask

  initial begin
    int seen;
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = '0;
    bus.cmd_const  = '0;
    bus.cmd_op     = '0;
    bus.cmd_repeat = '0;
    bus.res_ready  = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();
    check_reset_vals("idle");

    run_cmd("add",    8'h0A, 2'd1, 2'd0, 4'd2, 8'h13, 1'b0, 5'd3, 0);
    run_cmd("single", 8'h20, 2'd2, 2'd0, 4'd0, 8'h25, 1'b0, 5'd1, 0);
`ifdef SEQ_ZERO_STOP_EN
    run_cmd("subz",   8'h06, 2'd1, 2'd1, 4'd3, 8'h00, 1'b1, 5'd2, 0);
    run_cmd("wrap",   8'hFE, 2'd0, 2'd0, 4'd2, 8'h00, 1'b1, 5'd2, 0);
    run_cmd("and",    8'h0E, 2'd0, 2'd2, 4'd2, 8'h00, 1'b1, 5'd1, 0);
`else
    run_cmd("subz",   8'h06, 2'd1, 2'd1, 4'd3, 8'hFA, 1'b0, 5'd4, 0);
    run_cmd("wrap",   8'hFE, 2'd0, 2'd0, 4'd2, 8'h01, 1'b0, 5'd3, 0);
    run_cmd("and",    8'h0E, 2'd0, 2'd2, 4'd2, 8'h00, 1'b1, 5'd3, 0);
`endif
    run_cmd("or",     8'hF0, 2'd3, 2'd3, 4'd1, 8'hF7, 1'b0, 5'd2, 0);
    run_cmd("maxrep", 8'h00, 2'd3, 2'd0, 4'd15, 8'h70, 1'b0, 5'd16, 0);
    run_cmd("bkpr",   8'h0A, 2'd1, 2'd0, 4'd2, 8'h13, 1'b0, 5'd3, 5);

    // reset during the second iteration of a long command
    bus.cmd_valid  = 1'b1;
    bus.cmd_data   = 8'h10;
    bus.cmd_const  = 2'd0;
    bus.cmd_op     = 2'd0;
    bus.cmd_repeat = 4'd15;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("rst_pre_in", alu_input, 8'h11);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h55;
    tick();
    tick();
    check_reset_vals("rst_hold");
    bus.cmd_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    check_reset_vals("rst_release");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.res_valid) seen++;
    end
    check("rst_no_result", seen, 0);
    run_cmd("post_rst", 8'h0A, 2'd1, 2'd0, 4'd2, 8'h13, 1'b0, 5'd3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/comb_op_sequencer.md
# comb_op_sequencer

Sequential command front-end for the 8-bit constant ALU (`Comb`). Accepts operation commands over a valid/ready handshake and drives the ALU operand, constant-select and operation inputs. Feeds the ALU result back as the next operand for a programmable number of iterations, then presents the final result, zero flag and iteration count on a valid/ready result port. Sits between the control path and the combinational ALU and owns every ALU input.

## Interface
- REPEAT_W, 4, width of the repeat field; a command performs cmd_repeat+1 iterations (1..2^REPEAT_W).
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_data  in  8  initial operand.
- cmd_const  in  2  constant select passed to ALU (0:1, 1:3, 2:5, 3:7).
- cmd_op  in  2  ALU operation (0 add, 1 sub, 2 AND, 3 OR).
- cmd_repeat  in  REPEAT_W  extra iterations.
- alu_input  out  8  to ALU MyInput.
- alu_const_sel  out  2  to ALU MyConstantSelect.
- alu_op  out  2  to ALU MyOperation.
- alu_output  in  8  from ALU MyOutput.
- alu_status  in  1  from ALU MyStatus (1 = result zero).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  final accumulator value.
- res_zero  out  1  res_data == 0.
- res_iters  out  REPEAT_W+1  iterations actually performed.

## Operation
- States: IDLE, RUN, DONE. Reset to IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: acc<=cmd_data, latch const/op, count<=cmd_repeat, iters<=0, go RUN.
- RUN: alu_input=acc, alu_const_sel/alu_op = latched values (registered, stable for whole command). Each edge: acc<=alu_output, iters<=iters+1. If count==0 (or early stop, see Configuration) go DONE, else count<=count-1.
- DONE: res_valid=1; res_data=acc, res_zero=(acc==0), res_iters=iters held stable. On res_ready go IDLE.
- cmd_ready=0 in RUN and DONE; cmd_valid there is ignored (no overlap of command and result).
- ALU arithmetic is 8-bit mod 256; sequencer applies no saturation and never inspects carry. Result value is whatever the ALU returns.
- Latched command fields never change mid-command, regardless of cmd_* toggling.
- In IDLE and DONE: alu_input=0, alu_const_sel=0, alu_op=0.

## Timing
- Reset values: cmd_ready=1, res_valid=0, res_data=0, res_zero=0, res_iters=0, alu_input=0, alu_const_sel=0, alu_op=0.
- Latency: acceptance at edge E0; iterations at edges E1..E(k); res_valid high in the cycle after E(k), k = iterations performed (k=cmd_repeat+1 without early stop). Minimum k=1.
- Result handshake: transfer on res_valid&&res_ready edge; cmd_ready=1 the cycle after. Throughput: one command per k+2 cycles with res_ready held high.
- res_ready low: DONE holds indefinitely, outputs unchanged.
- reset_n asserted mid-RUN or mid-DONE: immediately IDLE, all outputs to reset values, in-flight result discarded; commands presented while reset_n low are not accepted.
- All outputs registered; no combinational path from cmd_* or res_ready to any output.

## Configuration
- SEQ_ZERO_STOP_EN defined: in RUN, if alu_status==1 the current iteration still commits (acc<=0, iters+1) and the state goes DONE regardless of count; res_iters reports the shortened count.
- Not defined: alu_status is ignored; every command runs exactly cmd_repeat+1 iterations. res_zero still computed from acc.

## Test plan
- Add: cmd_data=0x0A, cmd_const=1, cmd_op=0, cmd_repeat=2 -> res_data=0x13, res_zero=0, res_iters=3, res_valid 3 cycles after acceptance edge.
- Single iteration: cmd_data=0x20, cmd_const=2, cmd_op=0, cmd_repeat=0 -> res_data=0x25, res_iters=1, res_valid 1 cycle after acceptance.
- Sub through zero: cmd_data=0x06, cmd_const=1, cmd_op=1, cmd_repeat=3 -> with SEQ_ZERO_STOP_EN: res_data=0x00, res_zero=1, res_iters=2; without: res_data=0xFA, res_zero=0, res_iters=4.
- Wrap: cmd_data=0xFE, cmd_const=0, cmd_op=0, cmd_repeat=2, macro undefined -> res_data=0x01, res_iters=3.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while toggling cmd_valid and cmd_* -> res_* stable, cmd_ready=0, no command accepted; res_ready=1 -> cmd_ready=1 next cycle.
- Reset mid-RUN: cmd_repeat=15, drop reset_n during 2nd iteration -> all outputs at reset values immediately, no res_valid; after release a new add command completes correctly.
